// File: rtl/loader_pkg.sv
// Shared types and default sizing for the program loader and its helpers.
package loader_pkg;

    // Default instruction-memory address width (program counter width).
    localparam int DEF_D  = 12;
    // Default machine-code word width.
    localparam int DEF_W  = 9;
    // Default run-cycle counter width.
    localparam int DEF_CW = 16;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        BOOT = 3'd2,
        RUN  = 3'd3,
        HALT = 3'd4,
        ERR  = 3'd5
    } loaderState_t;

    // A load or a core run is in progress.
    function automatic logic isBusy(input loaderState_t s);
        return (s == LOAD) || (s == BOOT) || (s == RUN);
    endfunction

    // States from which a new program load may be started.
    function automatic logic canStartLoad(input loaderState_t s);
        return (s == IDLE) || (s == HALT) || (s == ERR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter
    import loader_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    logic [CW-1:0] countReg;

    // Clear wins over enable; once at all-ones the count holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (enable && (countReg != '1)) begin
            countReg <= countReg + CW'(1);
        end
    end

    assign count = countReg;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, holds the core in reset while
// loading, releases it, and times the run until the core reports done.
module prog_loader
    import loader_pkg::*;
#(
    parameter int D  = DEF_D,
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          wr_valid,
    input  logic [W-1:0]  wr_data,
    input  logic          wr_last,
    output logic          wr_ready,
    output logic          imem_we,
    output logic [D-1:0]  imem_addr,
    output logic [W-1:0]  imem_wdata,
    output logic          cpu_reset,
    input  logic          cpu_done,
    output logic          busy,
    output logic          halted,
    output logic          load_err,
    output logic [D:0]    words_loaded,
    output logic [CW-1:0] run_cycles
);

    loaderState_t stateReg;
    logic [D-1:0] addrReg;
    logic [D:0]   wordsReg;

    logic accept;
    logic startLoad;
    logic addrAtTop;
    logic runClear;
    logic runEnable;

    // A word is taken only while loading; wr_valid elsewhere is dropped.
    assign accept    = (stateReg == LOAD) && wr_valid;
    assign startLoad = load_start && canStartLoad(stateReg);
    assign addrAtTop = (addrReg == '1);

    // Run counter is zeroed when a new load starts and again on the boot cycle,
    // and counts every cycle the core is out of reset, including the done cycle.
    assign runClear  = startLoad || (stateReg == BOOT);
    assign runEnable = (stateReg == RUN);

    // Sequencing, write address and word count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg <= IDLE;
            addrReg  <= '0;
            wordsReg <= '0;
        end else begin
            case (stateReg)
                IDLE, HALT, ERR: begin
                    if (load_start) begin
                        stateReg <= LOAD;
                        addrReg  <= '0;
                        wordsReg <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        addrReg  <= addrReg + D'(1);
                        wordsReg <= wordsReg + (D+1)'(1);
                        if (wr_last) begin
                            stateReg <= BOOT;
                        end else if (addrAtTop) begin
                            // Memory is full and the program did not end.
                            stateReg <= ERR;
                        end
                    end
                end
                BOOT: begin
                    stateReg <= RUN;
                end
                RUN: begin
                    if (cpu_done) begin
                        stateReg <= HALT;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .CW(CW)
    ) uRunCounter (
        .clk    (clk),
        .reset  (reset),
        .clear  (runClear),
        .enable (runEnable),
        .count  (run_cycles)
    );

    // Outputs decoded from the state register and the current handshake.
    assign wr_ready     = (stateReg == LOAD);
    assign imem_we      = accept;
    assign imem_addr    = accept ? addrReg : '0;
    assign imem_wdata   = accept ? wr_data : '0;
    assign cpu_reset    = (stateReg != RUN);
    assign busy         = isBusy(stateReg);
    assign halted       = (stateReg == HALT);
    assign load_err     = (stateReg == ERR);
    assign words_loaded = wordsReg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus predicts memory writes into a
// queue, a negedge monitor pops and compares every write the DUT performs.
module tb_prog_loader;

    localparam int D      = 4;
    localparam int W      = 9;
    localparam int CW     = 4;
    localparam int DEPTH  = 1 << D;
    localparam int SATMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_last = 1'b0;
    logic          cpu_done = 1'b0;
    logic          wr_ready;
    logic          imem_we;
    logic [D-1:0]  imem_addr;
    logic [W-1:0]  imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          halted;
    logic          load_err;
    logic [D:0]    words_loaded;
    logic [CW-1:0] run_cycles;

    int errors = 0;
    int checks = 0;

    logic [D+W-1:0] expQ[$];
    logic [D+W-1:0] monExp;
    logic [W-1:0]   progData[0:63];

    always #5 clk = ~clk;

    prog_loader #(
        .D (D),
        .W (W),
        .CW(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset   (cpu_reset),
        .cpu_done    (cpu_done),
        .busy        (busy),
        .halted      (halted),
        .load_err    (load_err),
        .words_loaded(words_loaded),
        .run_cycles  (run_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write the DUT makes must match the oldest predicted write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                monExp = expQ.pop_front();
                $display("write addr=%0d data=%h", imem_addr, imem_wdata);
                chk("write_addr", 32'(imem_addr), 32'(monExp[D+W-1:W]));
                chk("write_data", 32'(imem_wdata), 32'(monExp[W-1:0]));
            end
        end else if (imem_we !== 1'b0) begin
            chk("imem_we_known", 32'(imem_we), 32'd0);
        end
    end

    task automatic expectStatus(input string tag, input logic b, input logic cr, input logic rdy,
                                input logic h, input logic e, input int w, input int r);
        chk({tag, ".busy"},         32'(busy),         32'(b));
        chk({tag, ".cpu_reset"},    32'(cpu_reset),    32'(cr));
        chk({tag, ".wr_ready"},     32'(wr_ready),     32'(rdy));
        chk({tag, ".halted"},       32'(halted),       32'(h));
        chk({tag, ".load_err"},     32'(load_err),     32'(e));
        chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(w));
        chk({tag, ".run_cycles"},   32'(run_cycles),   32'(r));
    endtask

    task automatic doReset();
        wr_valid   = 1'b0;
        load_start = 1'b0;
        cpu_done   = 1'b0;
        wr_last    = 1'b0;
        reset      = 1'b0;
        tick();
        expectStatus("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        wr_valid = 1'b1;
        wr_data  = W'($urandom);
        #1;
        chk("reset.imem_we",    32'(imem_we),    32'd0);
        chk("reset.imem_addr",  32'(imem_addr),  32'd0);
        chk("reset.imem_wdata", 32'(imem_wdata), 32'd0);
        wr_valid = 1'b0;
        tick();
        reset = 1'b1;
        $display("reset applied");
    endtask

    // mode 0: valid every cycle, 1: alternating, 2: random gaps.
    // stopAfter > 0 abandons the load after that many accepted words.
    task automatic loadProg(input int n, input bit withLast, input int mode, input int stopAfter);
        int  idx;
        int  budget;
        bit  done;
        bit  v;
        idx    = 0;
        budget = 0;
        done   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        expectStatus("load_start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        while (!done && budget < 500) begin
            budget++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 1;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            if (v) begin
                wr_valid   = 1'b1;
                wr_data    = progData[idx];
                wr_last    = withLast && (idx == n - 1);
                load_start = ($urandom_range(0, 3) == 0);
                expQ.push_back({D'(idx), progData[idx]});
                tick();
                idx++;
                if (wr_last || idx == DEPTH || (stopAfter > 0 && idx == stopAfter)) begin
                    done = 1'b1;
                end
            end else begin
                wr_valid   = 1'b0;
                wr_data    = W'($urandom);
                wr_last    = 1'($urandom);
                load_start = 1'($urandom);
                tick();
            end
        end
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        load_start = 1'b0;
        if (!done) begin
            chk("load_budget", 32'd0, 32'd1);
        end
    endtask

    task automatic runCore(input int k, input int words);
        for (int c = 1; c <= k; c++) begin
            cpu_done   = (c == k);
            load_start = ($urandom_range(0, 3) == 0);
            chk("run.cpu_reset", 32'(cpu_reset), 32'd0);
            tick();
        end
        cpu_done   = 1'b0;
        load_start = 1'b0;
        expectStatus("halt", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, words, (k > SATMAX) ? SATMAX : k);
    endtask

    // One complete load, and if the load ends properly, boot and run for runLen cycles.
    task automatic session(input int n, input bit withLast, input int mode, input int runLen);
        bit expErr;
        int expWords;
        int expRun;
        expErr   = !(withLast && n <= DEPTH);
        expWords = expErr ? DEPTH : n;
        expRun   = (runLen > SATMAX) ? SATMAX : runLen;
        loadProg(n, withLast, mode, 0);
        if (expErr) begin
            expectStatus("err", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, expWords, 0);
            wr_valid = 1'b1;
            wr_data  = W'($urandom);
            cpu_done = 1'b1;
            tick();
            wr_valid = 1'b0;
            cpu_done = 1'b0;
            expectStatus("err_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, expWords, 0);
        end else begin
            expectStatus("boot", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, expWords, 0);
            tick();
            expectStatus("run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, expWords, 0);
            runCore(runLen, expWords);
            wr_valid = 1'b1;
            wr_data  = W'($urandom);
            cpu_done = 1'b1;
            tick();
            wr_valid = 1'b0;
            cpu_done = 1'b0;
            expectStatus("halt_hold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, expWords, expRun);
        end
        $display("session n=%0d last=%0d mode=%0d words=%0d err=%0d run=%0d",
                 n, withLast, mode, expWords, expErr, expErr ? 0 : expRun);
    endtask

    task automatic randomData();
        for (int i = 0; i < 64; i++) begin
            progData[i] = W'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        randomData();
        doReset();

        // cpu_done while idle must not start or mark anything.
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        expectStatus("idle_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Three-word program, valid every cycle, core done on its 10th cycle.
        progData[0] = 9'h1A0;
        progData[1] = 9'h0C5;
        progData[2] = 9'h1FF;
        session(3, 1'b1, 0, 10);

        // Alternating valid with two words.
        progData[0] = 9'h011;
        progData[1] = 9'h022;
        session(2, 1'b1, 1, 3);

        // Overflow without wr_last, then a fresh load from address 0.
        randomData();
        session(DEPTH + 4, 1'b0, 0, 0);
        randomData();
        session(4, 1'b1, 2, 2);

        // Exactly full memory with wr_last on the final word is not an error.
        randomData();
        session(DEPTH, 1'b1, 2, 1);

        // Single word program, run long enough to saturate the counter.
        randomData();
        session(1, 1'b1, 0, 20);

        // Reset after the second accepted word, then a clean load.
        randomData();
        loadProg(6, 1'b1, 0, 2);
        doReset();
        randomData();
        session(5, 1'b1, 2, 7);

        // Reset in the middle of a run.
        randomData();
        loadProg(3, 1'b1, 0, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        chk("midrun.run_cycles", 32'(run_cycles), 32'd5);
        doReset();
        randomData();
        session(2, 1'b1, 0, 4);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            randomData();
            session($urandom_range(1, DEPTH + 3), ($urandom_range(0, 4) != 0), 2,
                    $urandom_range(1, 25));
        end

        tick();
        tick();
        chk("queue_empty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
